multiport_pmem: RTL

MULTIPORT_PMEM -- requirements
Module: multiport_pmem

---
 rtl/multiport_pmem_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 45 ++++
 rtl/multiport_pmem.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/multiport_pmem_pkg.sv
// Shared types and width helpers for the multi-port line memory.
package pmem_types;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  // Number of byte-offset bits inside one line.
  function automatic int off_width(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Number of line-index bits left above the byte offset.
  function automatic int idx_width(input int addr_w, input int line_w);
    return addr_w - off_width(line_w);
  endfunction

  // Widths for the default geometry (16-bit address, 128-bit line).
  localparam int OFF_W = off_width(128);
  localparam int IDX_W = idx_width(16, 128);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: one-hot grant, search starts after the last winner.
module rr_arbiter #(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 advance,
  output logic [NUM_PORTS-1:0] grant
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [PW-1:0] last;
  logic [PW-1:0] pick;
  logic          found;
  int            j;

  // Scan ports last+1, last+2, ... wrapping; the first requester wins.
  always_comb begin
    grant = '0;
    pick  = last;
    found = 1'b0;
    j     = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      j = int'(last) + i;
      if (j >= NUM_PORTS) j = j - NUM_PORTS;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
    if (found) grant[pick] = 1'b1;
  end

  // Remember the winner; reset points at the last port so port 0 leads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= PW'(NUM_PORTS - 1);
    end else if (advance && found) begin
      last <= pick;
    end
  end

endmodule

// File: rtl/multiport_pmem.sv
// Multi-port line memory: one transaction at a time, fixed grant-to-resp
// latency, round-robin between requesters.
// Handshake: a requester raises read or write and holds it (with address and
// wdata) until its resp bit pulses for one cycle; rdata and err are only
// meaningful during that pulse and are zero otherwise.
module multiport_pmem
  import pmem_types::*;
#(
  parameter int NUM_PORTS   = 2,
  parameter int ADDR_W      = 16,
  parameter int LINE_W      = 128,
  parameter int DEPTH_LINES = 512,
  parameter int LATENCY     = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              read,
  input  logic [NUM_PORTS-1:0]              write,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  address,
  input  logic [NUM_PORTS-1:0][LINE_W-1:0]  wdata,
  output logic [NUM_PORTS-1:0]              resp,
  output logic [LINE_W-1:0]                 rdata,
  output logic                              err,
  output pmem_state_t                       fsm_state
);

  localparam int LOFF_W     = off_width(LINE_W);
  localparam int LIDX_W     = idx_width(ADDR_W, LINE_W);
  localparam int LINE_IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int PORT_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  pmem_state_t state, state_next;
  logic [CNT_W-1:0] cnt;

  logic [NUM_PORTS-1:0] req;
  logic                 any_req;
  logic                 advance;
  logic [NUM_PORTS-1:0] grant;
  logic [PORT_W-1:0]    grant_idx;

  logic [ADDR_W-1:0]    sel_addr;
  logic [LIDX_W-1:0]    sel_idx;
  logic                 sel_oob;
  logic                 sel_conflict;

  logic [PORT_W-1:0]     cap_idx;
  logic                  cap_write;
  logic                  cap_read;
  logic                  cap_err;
  logic [LINE_IDX_W-1:0] cap_line;
  logic [LINE_W-1:0]     cap_wdata;

  // Array is deliberately not reset; contents survive rst.
  logic [LINE_W-1:0] mem [DEPTH_LINES];

  assign req       = read | write;
  assign any_req   = |req;
  assign advance   = (state == IDLE) && any_req;
  assign fsm_state = state;

  rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .advance (advance),
    .grant   (grant)
  );

  // Convert the one-hot grant into a port index.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant[i]) grant_idx = PORT_W'(i);
    end
  end

  // Decode the granted port's request: line index, range and op conflict.
  always_comb begin
    sel_addr     = address[grant_idx];
    sel_idx      = LIDX_W'(sel_addr >> LOFF_W);
    sel_oob      = int'(sel_idx) >= DEPTH_LINES;
    sel_conflict = read[grant_idx] & write[grant_idx];
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic: grant, count down the latency, one RESP cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (any_req) state_next = (LATENCY == 1) ? RESP : BUSY;
      BUSY: if (cnt == CNT_ONE) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Latency counter and captured request; captured values ride out the
  // transaction even if the requester drops its inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      cap_idx   <= '0;
      cap_read  <= 1'b0;
      cap_write <= 1'b0;
      cap_err   <= 1'b0;
      cap_line  <= '0;
      cap_wdata <= '0;
    end else begin
      if (advance) begin
        cnt       <= CNT_LOAD;
        cap_idx   <= grant_idx;
        cap_read  <= read[grant_idx];
        cap_write <= write[grant_idx];
        cap_err   <= sel_oob | sel_conflict;
        cap_line  <= LINE_IDX_W'(sel_idx);
        cap_wdata <= wdata[grant_idx];
      end else if (state == BUSY) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  // Outputs: only the serviced port sees resp, and only in RESP.
  always_comb begin
    resp  = '0;
    err   = 1'b0;
    rdata = '0;
    if (state == RESP) begin
      resp[cap_idx] = 1'b1;
      err           = cap_err;
      if (cap_read && !cap_err) rdata = mem[cap_line];
    end
  end

  // Write commits on the edge that leaves RESP; errors never write.
  always_ff @(posedge clk) begin
    if (!rst && state == RESP && cap_write && !cap_err) begin
      mem[cap_line] <= cap_wdata;
    end
  end

endmodule
